// File: rtl/cache_mem_responder_pkg.sv
// rtl/cache_mem_responder_pkg.sv - shared cache types plus backing-memory responder helpers
package cache_mem_responder_pkg;

    localparam int TAG_SIZE    = 17;
    localparam int INDEX_SIZE  = 11;
    localparam int BLOCK_SIZE  = 2;
    localparam int MEM_LATENCY = 4;

    typedef struct packed {
        logic                         valid;
        logic                         dirty;
        logic                         lru;
        logic [TAG_SIZE-1:0]          tag;
        logic [BLOCK_SIZE-1:0][31:0]  block;
    } block_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} mem_state_t;

    // Word address of word i of block {tag, index}, before wrapping to the RAM depth.
    function automatic logic [31:0] blk_word_addr(input logic [TAG_SIZE-1:0] tag,
                                                  input logic [INDEX_SIZE-1:0] index,
                                                  input int unsigned i);
        logic [31:0] blk_num;
        blk_num = 32'({tag, index});
        return blk_num * 32'(BLOCK_SIZE) + 32'(i);
    endfunction

endpackage

// File: rtl/cache_mem_responder_ram.sv
// rtl/cache_mem_responder_ram.sv - word RAM with block read, block writeback and preload ports
module mem_ram_array
    import cache_mem_responder_pkg::*;
#(
    parameter int RAM_SIZE = 65536,
    localparam int AW = $clog2(RAM_SIZE)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             rd_en_i,
    input  logic [BLOCK_SIZE-1:0][AW-1:0]    rd_addr_i,
    input  logic                             wb_en_i,
    input  logic [BLOCK_SIZE-1:0][AW-1:0]    wb_addr_i,
    input  logic [BLOCK_SIZE-1:0][31:0]      wb_data_i,
    input  logic                             ld_en_i,
    input  logic [AW-1:0]                    ld_addr_i,
    input  logic [31:0]                      ld_data_i,
    output logic [BLOCK_SIZE-1:0][31:0]      rd_data_o
);

    logic [31:0]                 mem_q [RAM_SIZE];
    logic [BLOCK_SIZE-1:0][31:0] rd_data_d;
    logic [BLOCK_SIZE-1:0][31:0] rd_data_q;

    // Array writes; the writeback is issued last so it overrides a preload to the same word.
    always_ff @(posedge clock) begin
        if (ld_en_i) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end
        if (wb_en_i) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                mem_q[wb_addr_i[j]] <= wb_data_i[j];
            end
        end
    end

    // Read data with same-edge preload/writeback forwarding, writeback taking priority.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            rd_data_d[i] = mem_q[rd_addr_i[i]];
            if (ld_en_i && (ld_addr_i == rd_addr_i[i])) begin
                rd_data_d[i] = ld_data_i;
            end
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                if (wb_en_i && (wb_addr_i[j] == rd_addr_i[i])) begin
                    rd_data_d[i] = wb_data_i[j];
                end
            end
        end
    end

    // Read register; holds the last returned block between responses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - fixed-latency backing memory serving cache fills and writebacks
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int RAM_SIZE = 65536,
    parameter int LATENCY  = MEM_LATENCY,
    localparam int AW = $clog2(RAM_SIZE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [31:0]   mem_addr,
    input  block_t        mem_wb_block,
    output logic          mem_miss,
    output block_t        mem_req_blk,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic [31:0]   fill_count,
    output logic [31:0]   wb_count
);

    mem_state_t              state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [TAG_SIZE-1:0]     tag_q, tag_d;
    logic [INDEX_SIZE-1:0]   index_q, index_d;
    logic [INDEX_SIZE-1:0]   last_index_q, last_index_d;
    logic [TAG_SIZE-1:0]     resp_tag_q;
    logic                    resp_valid_q;
    logic [31:0]             fill_count_q, wb_count_q;
    logic                    enter_resp;

    logic [BLOCK_SIZE-1:0][AW-1:0] rd_addr, wb_addr;
    logic [BLOCK_SIZE-1:0][31:0]   rd_data;
    logic                          unused_ok;

    assign unused_ok = ^{mem_addr[31:TAG_SIZE+INDEX_SIZE+2], mem_addr[1:0],
                         mem_wb_block.valid, mem_wb_block.dirty, mem_wb_block.lru};

    // Next state: every latency, including 1, passes through WAIT so RESP lands LATENCY edges after acceptance.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        index_d      = index_q;
        last_index_d = last_index_q;
        enter_resp   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    tag_d        = mem_addr[TAG_SIZE+INDEX_SIZE+1:INDEX_SIZE+2];
                    index_d      = mem_addr[INDEX_SIZE+1:2];
                    last_index_d = mem_addr[INDEX_SIZE+1:2];
                    cnt_d        = 8'(LATENCY - 1);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP:    state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word addresses for the pending fill and for the victim block at the last filled index.
    always_comb begin
        rd_addr = '0;
        wb_addr = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            rd_addr[i] = AW'(blk_word_addr(tag_q, index_q, i) % 32'(RAM_SIZE));
            wb_addr[i] = AW'(blk_word_addr(mem_wb_block.tag, last_index_q, i) % 32'(RAM_SIZE));
        end
    end

    // State, request latches, response header and counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            index_q      <= '0;
            last_index_q <= '0;
            resp_tag_q   <= '0;
            resp_valid_q <= 1'b0;
            fill_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            last_index_q <= last_index_d;
            if (enter_resp) begin
                resp_tag_q   <= tag_q;
                resp_valid_q <= 1'b1;
            end
            if (state_q == RESP) begin
                fill_count_q <= fill_count_q + 32'd1;
            end
            if (mem_we) begin
                wb_count_q <= wb_count_q + 32'd1;
            end
        end
    end

    mem_ram_array #(.RAM_SIZE(RAM_SIZE)) u_ram (
        .clock     (clock),
        .reset     (reset),
        .rd_en_i   (enter_resp),
        .rd_addr_i (rd_addr),
        .wb_en_i   (mem_we),
        .wb_addr_i (wb_addr),
        .wb_data_i (mem_wb_block.block),
        .ld_en_i   (ld_en),
        .ld_addr_i (ld_addr),
        .ld_data_i (ld_data),
        .rd_data_o (rd_data)
    );

    // Response block assembled from the registered header and RAM read register.
    always_comb begin
        mem_req_blk       = '0;
        mem_req_blk.valid = resp_valid_q;
        mem_req_blk.tag   = resp_tag_q;
        mem_req_blk.block = rd_data;
    end

    assign mem_miss   = (state_q != RESP);
    assign fill_count = fill_count_q;
    assign wb_count   = wb_count_q;

endmodule
